// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves RV32I control-flow instructions (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/
// JALR) in EX. It also keeps a direct-mapped table of 2-bit saturating
// counters (BHT) that fetch reads for predictions. It issues a registered
// one-cycle redirect/flush to the front end, and counts resolved branches
// and branch mispredicts.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   f_pc            fetch PC used for the BHT lookup
//   f_pred_taken    combinational prediction (MSB of the indexed counter)
//   ex_valid        EX holds a valid instruction
//   ex_branch/jal/jalr  instruction type (jalr > jal > branch)
//   ex_funct3       branch condition select
//   ex_pc, ex_imm   PC and sign-extended immediate of the EX instruction
//   ex_rs1, ex_rs2  operands
//   ex_pred_taken   prediction carried from fetch
//   redirect, redirect_pc, flush   registered front-end redirect
//   branch_cnt, mispredict_cnt     wrapping performance counters
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  // Saturating 2-bit counter step toward taken (up=1) or not-taken (up=0).
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]       r_bht [BHT_ENTRIES];
  logic             r_redirect;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  logic             w_accept;
  logic             w_taken;
  logic             w_legal;
  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic [XLEN-1:0]  w_br_target;
  logic [XLEN-1:0]  w_jalr_target;
  logic [XLEN-1:0]  w_fallthru;
  logic             w_redirect_nxt;
  logic [XLEN-1:0]  w_redirect_pc_nxt;
  logic             w_bht_we;
  logic             w_mispredict;
  logic             w_unused_pc_bits;

  assign w_f_idx          = f_pc[IDX_W+1:2];
  assign w_ex_idx         = ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

  // Prediction is read straight from the table: a same-cycle write is not
  // bypassed, so fetch sees the old counter until the next cycle.
  assign f_pred_taken = r_bht[w_f_idx][1];

  // An instruction sitting in EX while a redirect is out is wrong-path.
  assign w_accept = ex_valid & ~r_redirect;

  assign w_br_target   = ex_pc + ex_imm;
  assign w_jalr_target = (ex_rs1 + ex_imm) & ~(XLEN'(32'd1));
  assign w_fallthru    = ex_pc + PC_STEP;

  // Branch condition evaluation; funct3 010/011 are illegal (not taken).
  always_comb begin
    w_taken = 1'b0;
    w_legal = 1'b1;
    case (ex_funct3)
      3'b000:  w_taken = (ex_rs1 == ex_rs2);
      3'b001:  w_taken = (ex_rs1 != ex_rs2);
      3'b100:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  w_taken = (ex_rs1 <  ex_rs2);
      3'b111:  w_taken = (ex_rs1 >= ex_rs2);
      default: begin
        w_taken = 1'b0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Redirect / BHT-update / mispredict decision for the accepted instruction.
  always_comb begin
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_bht_we          = 1'b0;
    w_mispredict      = 1'b0;
    if (w_accept) begin
      if (ex_jalr) begin
        w_redirect_nxt    = 1'b1;
        w_redirect_pc_nxt = w_jalr_target;
      end else if (ex_jal) begin
        w_redirect_nxt    = 1'b1;
        w_redirect_pc_nxt = w_br_target;
      end else if (ex_branch && w_legal) begin
        w_bht_we = 1'b1;
        // Correct predictions need no redirect: fetch already followed them.
        if (w_taken != ex_pred_taken) begin
          w_mispredict      = 1'b1;
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = w_taken ? w_br_target : w_fallthru;
        end else begin
          w_mispredict = 1'b0;
        end
      end else begin
        w_redirect_nxt = 1'b0;
      end
    end else begin
      w_redirect_nxt = 1'b0;
    end
  end

  // Redirect outputs and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect       <= 1'b0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      if (w_bht_we) begin
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      end
      if (w_mispredict) begin
        r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
      end
    end
  end

  // Branch history table: reset to weakly not-taken, train on legal branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_bht_we) begin
      r_bht[w_ex_idx] <= sat_step(r_bht[w_ex_idx], w_taken);
    end
  end

  assign redirect       = r_redirect;
  assign flush          = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule
